// File: rtl/encoder8_3_seq_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared constants, state encoding and popcount helper for the sequential
// 8-to-3 encoder (encoder8_3_seq) and its priority selector (prio_sel8).
// ---------------------------------------------------------------------------
package enc_pkg;

   localparam int N_IN  = 8;   // request word width
   localparam int N_OUT = 3;   // binary code width, clog2(N_IN)
   localparam int CNT_W = 4;   // popcount width, holds 0..8

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Number of set bits in an N_IN-bit word.
   function automatic logic [CNT_W-1:0] popcount8(input logic [N_IN-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_IN; i++) begin
         c = c + {{(CNT_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/encoder8_3_seq_prio_sel8.sv
// ---------------------------------------------------------------------------
// prio_sel8
// Combinational priority selector over the pending request word.
//   pending_i  [N_IN-1:0]  in   bits still waiting to be emitted
//   idx_o      [N_OUT-1:0] out  index of the selected set bit (0 if none)
//   clr_mask_o [N_IN-1:0]  out  one-hot mask of the selected bit (0 if none)
//   any_o                  out  at least one bit of pending_i is set
// PRIO_HIGH_FIRST = 0 selects the lowest set bit, 1 the highest.
// ---------------------------------------------------------------------------
module prio_sel8
   import enc_pkg::*;
#(
   parameter int PRIO_HIGH_FIRST = 0
) (
   input  logic [N_IN-1:0]  pending_i,
   output logic [N_OUT-1:0] idx_o,
   output logic [N_IN-1:0]  clr_mask_o,
   output logic             any_o
);

   always_comb begin
      idx_o      = '0;
      clr_mask_o = '0;
      any_o      = |pending_i;
      // The last match written wins, so the scan direction sets the priority.
      if (PRIO_HIGH_FIRST != 0) begin
         for (int i = 0; i < N_IN; i++) begin
            if (pending_i[i]) idx_o = N_OUT'(i);
         end
      end else begin
         for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending_i[i]) idx_o = N_OUT'(i);
         end
      end
      if (any_o) clr_mask_o = N_IN'(1) << idx_o;
   end

endmodule

// File: rtl/encoder8_3_seq.sv
// ---------------------------------------------------------------------------
// encoder8_3_seq
// Sequential 8-to-3 encoder. Captures a request word over a valid/ready
// handshake and emits the index of every set bit, one per output handshake,
// in priority order (lowest first, or highest first with PRIO_HIGH_FIRST=1).
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in         in   [8] request word
//   in_valid   in   word on 'in' is valid
//   in_ready   out  block can accept a word (IDLE and not in reset)
//   out        out  [3] index of the selected set bit
//   out_valid  out  'out' holds a valid code
//   out_ready  in   downstream accepts 'out'
//   out_last   out  final code of the current word
//   out_cnt    out  [4] popcount of the captured word
//   err        out  (only with ENC_ZERO_ERR_EN) one-cycle pulse when an
//                   all-zero word is accepted
// Optional feature macro: ENC_ZERO_ERR_EN.
// ---------------------------------------------------------------------------
module encoder8_3_seq
   import enc_pkg::*;
#(
   parameter int N_IN            = enc_pkg::N_IN,
   parameter int N_OUT           = enc_pkg::N_OUT,
   parameter int PRIO_HIGH_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N_OUT-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
`ifdef ENC_ZERO_ERR_EN
   output logic [CNT_W-1:0] out_cnt,
   output logic             err
`else
   output logic [CNT_W-1:0] out_cnt
`endif
);

   state_e             state_q, state_d;
   logic [N_IN-1:0]    pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef ENC_ZERO_ERR_EN
   logic               err_q, err_d;
`endif

   logic [N_OUT-1:0]   sel_idx;
   logic [N_IN-1:0]    sel_mask;
   logic               sel_any;
   logic               accept;

   prio_sel8 #(
      .PRIO_HIGH_FIRST (PRIO_HIGH_FIRST)
   ) u_sel (
      .pending_i  (pending_q),
      .idx_o      (sel_idx),
      .clr_mask_o (sel_mask),
      .any_o      (sel_any)
   );

   // Outputs are pure functions of the state and pending registers, so they
   // cannot move while the downstream stalls.
   assign in_ready  = (state_q == IDLE) & ~rst;
   assign accept    = in_valid & in_ready;
   assign out       = sel_idx;
   assign out_valid = (state_q == EMIT) & sel_any;
   assign out_last  = (popcount8(pending_q) == CNT_W'(1));
   assign out_cnt   = cnt_q;
`ifdef ENC_ZERO_ERR_EN
   assign err       = err_q;
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
`ifdef ENC_ZERO_ERR_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               pending_d = in;
               cnt_d     = popcount8(in);
               if (|in) begin
                  state_d = EMIT;
               end else begin
`ifdef ENC_ZERO_ERR_EN
                  err_d = 1'b1;
`endif
               end
            end
         end
         EMIT: begin
            if (out_valid && out_ready) begin
               pending_d = pending_q & ~sel_mask;
               if (out_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         cnt_q     <= '0;
`ifdef ENC_ZERO_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
`ifdef ENC_ZERO_ERR_EN
         err_q     <= err_d;
`endif
      end
   end

endmodule
